aes_hpc_reseed_scheduler: RTL and testbench
===========================================

Name: aes_hpc_reseed_scheduler

Overview:
- Control-only sequencer between the host and the masked 32-bit AES-128 core (aes_enc128_32bits_hpc).
- Enforces three rules: an initial PRNG reseed before the first encryption; a mandatory reseed after every RESEED_PERIOD encryptions; no reseed while an encryption is in flight.
- Only handshake signals pass through this block. Plaintext, key and seed data go directly to the core.

Parameters:
RESEED_PERIOD, 16, encryptions allowed between mandatory reseeds; 0 = only the initial reseed is mandatory
CNT_W, 16, width of the encryption counter; RESEED_PERIOD < 2**CNT_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
host_in_valid  in  1  host offers plaintext/key
host_in_ready  out  1  host input accepted this cycle
core_in_valid  out  1  to core in_valid
core_in_ready  in  1  from core in_ready
core_out_valid  in  1  core out_valid (monitored)
core_out_ready  in  1  out_ready as driven by the consumer (monitored)
host_seed_valid  in  1  host offers a fresh seed
host_seed_ready  out  1  seed accepted this cycle
core_seed_valid  out  1  to core in_seed_valid
core_seed_ready  in  1  from core in_seed_ready
seed_required  out  1  high while in NEED_SEED
busy  out  1  high while an encryption is in flight (RUN)
enc_cnt  out  CNT_W  encryptions accepted since last reseed

Behaviour:
- Reset (asynchronous, rst=1):
  - state=NEED_SEED, enc_cnt=0.
  - host_in_ready, core_in_valid, host_seed_ready, core_seed_valid, busy = 0; seed_required=1.
  - The same rst is expected to reset the core.
  - Reset mid-encryption or mid-seed aborts everything and returns to NEED_SEED.
- Handshakes:
  - A transfer occurs when valid&ready are both high on a rising clk edge.
  - All outputs are combinational from the state and the inputs. There is no data register, so pass-through latency is 0 cycles.
- Seed pass-through enable (SE) = (state==NEED_SEED) | (state==IDLE).
  - When SE=1: core_seed_valid=host_seed_valid and host_seed_ready=core_seed_ready.
  - When SE=0: both are 0.
- NEED_SEED:
  - core_in_valid=0, host_in_ready=0.
  - On a seed transfer: go to IDLE, enc_cnt<=0.
- IDLE:
  - A pending seed has priority. core_in_valid = host_in_valid & ~host_seed_valid, and host_in_ready = core_in_ready & ~host_seed_valid.
  - On a seed transfer: stay in IDLE, enc_cnt<=0 (voluntary reseed).
  - On an input transfer: go to RUN, enc_cnt<=enc_cnt+1.
  - The two transfers are mutually exclusive by construction.
- RUN:
  - busy=1. Input and seed paths are gated (all four valid/ready outputs are 0).
  - On core_out_valid&core_out_ready: if RESEED_PERIOD!=0 and enc_cnt==RESEED_PERIOD, go to NEED_SEED; else go to IDLE.
  - Host valids arriving in the same cycle as the output transfer are not accepted until the next cycle. This gives a one-cycle bubble minimum between encryptions.
- Counter:
  - enc_cnt saturates at 2**CNT_W-1. It only matters for RESEED_PERIOD=0.
  - It never wraps.
- A host that deasserts valid before a transfer is tolerated; no state change occurs.
- Only one encryption is in flight at any time.

Test Plan:
- Reset, then host_in_valid=1 with no seed -> host_in_ready and core_in_valid stay 0 for 50 cycles; seed_required=1.
- Initial seed: host_seed_valid=1, core_seed_ready asserted 3 cycles later -> host_seed_ready pulses 1 cycle; next cycle state IDLE, seed_required=0, enc_cnt=0.
- RESEED_PERIOD=2: run 2 encryptions against the core model with random out_ready back-pressure -> enc_cnt 1 then 2; after the second output transfer seed_required=1 and the third host_in_valid is blocked until a seed transfer; enc_cnt then returns to 0.
- In IDLE, assert host_in_valid and host_seed_valid in the same cycle -> seed transferred first, core_in_valid=0 that cycle; the input is accepted on the next ready cycle.
- In RUN, assert host_seed_valid -> core_seed_valid=0 until the output transfer; then the seed passes through in IDLE and enc_cnt resets to 0.
- Assert rst for 1 cycle mid-RUN (asynchronous, not clock-aligned) -> outputs immediately take their reset values: busy=0, seed_required=1, enc_cnt=0. The KAT plaintext/ciphertext sequence then passes after reseed.

Source files
------------

// File: rtl/aes_hpc_reseed_scheduler.sv
// rtl/aes_hpc_reseed_scheduler.sv - reseed/encryption handshake sequencer for the masked AES core
// Forces a PRNG reseed before first use and after every RESEED_PERIOD encryptions.
module aes_hpc_reseed_scheduler #(
  parameter int unsigned RESEED_PERIOD = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic             core_in_valid,
  input  logic             core_in_ready,
  input  logic             core_out_valid,
  input  logic             core_out_ready,
  input  logic             host_seed_valid,
  output logic             host_seed_ready,
  output logic             core_seed_valid,
  input  logic             core_seed_ready,
  output logic             seed_required,
  output logic             busy,
  output logic [CNT_W-1:0] enc_cnt
);

  typedef enum logic [1:0] {
    ST_NEED_SEED = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(RESEED_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam bit               PERIOD_EN = (RESEED_PERIOD != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic             seed_en;
  logic             seed_xfer, in_xfer, out_xfer;

  assign seed_xfer = core_seed_valid & core_seed_ready;
  assign in_xfer   = core_in_valid & core_in_ready;
  assign out_xfer  = (state_q == ST_RUN) & core_out_valid & core_out_ready;
  assign enc_cnt   = enc_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_NEED_SEED;
      enc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      enc_cnt_q <= enc_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    enc_cnt_d = enc_cnt_q;
    case (state_q)
      ST_NEED_SEED: begin
        if (seed_xfer) begin
          state_d   = ST_IDLE;
          enc_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (seed_xfer) begin
          enc_cnt_d = '0;
        end else if (in_xfer) begin
          state_d = ST_RUN;
          if (enc_cnt_q != CNT_MAX) enc_cnt_d = enc_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (out_xfer) begin
          state_d = (PERIOD_EN && (enc_cnt_q == PERIOD_C)) ? ST_NEED_SEED : ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_NEED_SEED;
        enc_cnt_d = '0;
      end
    endcase
  end

  // Seed path is also forced low while rst is held so the core sees no seed during reset.
  always_comb begin
    seed_en         = ~rst & ((state_q == ST_NEED_SEED) | (state_q == ST_IDLE));
    core_seed_valid = seed_en & host_seed_valid;
    host_seed_ready = seed_en & core_seed_ready;
    core_in_valid   = (state_q == ST_IDLE) & host_in_valid & ~host_seed_valid;
    host_in_ready   = (state_q == ST_IDLE) & core_in_ready & ~host_seed_valid;
    seed_required   = (state_q == ST_NEED_SEED);
    busy            = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_aes_hpc_reseed_scheduler.sv
// tb/tb_aes_hpc_reseed_scheduler.sv - self-checking bench for aes_hpc_reseed_scheduler
// Main instance uses RESEED_PERIOD=2; a second instance checks counter saturation with period 0.
module tb_aes_hpc_reseed_scheduler;

  localparam int unsigned P = 2;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic clk = 1'b0;
  logic rst;
  logic host_in_valid, host_in_ready, core_in_valid, core_in_ready;
  logic core_out_valid, core_out_ready;
  logic host_seed_valid, host_seed_ready, core_seed_valid, core_seed_ready;
  logic seed_required, busy;
  logic [15:0] enc_cnt;

  logic zhiv, zhir, zciv, zcir, zcov, zcor, zhsv, zhsr, zcsv, zcsr, zsreq, zbusy;
  logic [1:0] zcnt;

  always #5 clk = ~clk;

  aes_hpc_reseed_scheduler #(.RESEED_PERIOD(P), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .host_seed_valid(host_seed_valid), .host_seed_ready(host_seed_ready),
    .core_seed_valid(core_seed_valid), .core_seed_ready(core_seed_ready),
    .seed_required(seed_required), .busy(busy), .enc_cnt(enc_cnt)
  );

  aes_hpc_reseed_scheduler #(.RESEED_PERIOD(0), .CNT_W(2)) dut_z (
    .clk(clk), .rst(rst),
    .host_in_valid(zhiv), .host_in_ready(zhir),
    .core_in_valid(zciv), .core_in_ready(zcir),
    .core_out_valid(zcov), .core_out_ready(zcor),
    .host_seed_valid(zhsv), .host_seed_ready(zhsr),
    .core_seed_valid(zcsv), .core_seed_ready(zcsr),
    .seed_required(zsreq), .busy(zbusy), .enc_cnt(zcnt)
  );

  typedef struct {
    bit idle;
    bit hiv, hsv, cir, csr;
    bit e_hir, e_civ, e_hsr, e_csv;
  } vec_t;

  typedef struct {
    logic [15:0] cnt;
    bit          need;
  } exp_t;

  vec_t        vecs[9];
  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] m_cnt  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic clear_inputs();
    host_in_valid = 0; core_in_ready = 0; core_out_valid = 0; core_out_ready = 0;
    host_seed_valid = 0; core_seed_ready = 0;
  endtask

  task automatic do_seed(input int dly);
    @(negedge clk);
    host_seed_valid = 1; core_seed_ready = 0;
    for (int i = 0; i < dly; i++) begin
      #1 check("seed_wait", host_seed_ready, 0);
      @(negedge clk);
    end
    core_seed_ready = 1;
    #1 check("seed_ready", host_seed_ready, 1);
    @(negedge clk);
    host_seed_valid = 0; core_seed_ready = 0;
    #1;
    check("seed_req_clr", seed_required, 0);
    check("seed_cnt_clr", enc_cnt, 0);
    m_cnt = '0;
  endtask

  task automatic start_enc();
    exp_t e;
    int   n = 0;
    @(negedge clk);
    host_in_valid = 1; core_in_ready = 1;
    #1;
    while (!host_in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("in_accept", host_in_ready, 1);
    @(posedge clk);
    if (m_cnt != CNT_MAX) m_cnt++;
    e.cnt  = m_cnt;
    e.need = (P != 0) && (m_cnt == 16'(P));
    sb.push_back(e);
    @(negedge clk);
    #1;
    check("run_busy", busy, 1);
    check("run_cnt", enc_cnt, m_cnt);
    check("run_in_gate", {host_in_ready, core_in_valid}, 0);
    host_in_valid = 0; core_in_ready = 0;
  endtask

  task automatic finish_enc(input bit seed_in_run);
    exp_t e;
    int   n = 0;
    bit   done = 0;
    if (seed_in_run) begin
      host_seed_valid = 1; core_seed_ready = 1;
    end
    while (!done && n < 30) begin
      @(negedge clk);
      core_out_valid = (n >= 1);
      core_out_ready = (n >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (seed_in_run) check("run_seed_gate", {core_seed_valid, host_seed_ready}, 0);
      done = core_out_valid & core_out_ready;
      n++;
    end
    check("out_handshake", done, 1);
    @(negedge clk);
    core_out_valid = 0; core_out_ready = 0;
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("done_cnt", enc_cnt, e.cnt);
      check("done_seed_req", seed_required, e.need);
      check("done_busy", busy, 0);
    end
    if (seed_in_run) begin
      check("idle_seed_pass", core_seed_valid, 1);
      @(negedge clk);
      host_seed_valid = 0; core_seed_ready = 0;
      #1 check("run_seed_cnt", enc_cnt, 0);
      m_cnt = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [1:0] zm;

    //            idle hiv hsv cir csr | hir civ hsr csv
    vecs[0] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 1, 1, 0, 0, 0, 0, 1};
    vecs[2] = '{0, 0, 1, 0, 1, 0, 0, 1, 1};
    vecs[3] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
    vecs[4] = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
    vecs[5] = '{1, 1, 0, 0, 1, 0, 1, 1, 0};
    vecs[6] = '{1, 1, 1, 1, 1, 0, 0, 1, 1};
    vecs[7] = '{1, 0, 0, 1, 0, 1, 0, 0, 0};
    vecs[8] = '{1, 0, 1, 1, 0, 0, 0, 0, 1};

    clear_inputs();
    zhiv = 0; zcir = 0; zcov = 0; zcor = 0; zhsv = 0; zcsr = 0;
    rst = 1;
    host_seed_valid = 1; core_seed_ready = 1; host_in_valid = 1; core_in_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_seed_req", seed_required, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", enc_cnt, 0);
    check("rst_paths", {host_in_ready, core_in_valid, host_seed_ready, core_seed_valid}, 0);
    rst = 0;
    clear_inputs();

    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) do_seed(3);
      for (int i = 0; i < 9; i++) begin
        if (vecs[i].idle == bit'(pass)) begin
          @(negedge clk);
          host_in_valid = vecs[i].hiv; host_seed_valid = vecs[i].hsv;
          core_in_ready = vecs[i].cir; core_seed_ready = vecs[i].csr;
          #1;
          check($sformatf("vec%0d", i),
                {host_in_ready, core_in_valid, host_seed_ready, core_seed_valid},
                {vecs[i].e_hir, vecs[i].e_civ, vecs[i].e_hsr, vecs[i].e_csv});
          clear_inputs();
        end
      end
      if (pass == 0) begin
        ok = 1;
        host_in_valid = 1; core_in_ready = 1;
        repeat (50) begin
          @(negedge clk); #1;
          if (host_in_ready || core_in_valid || !seed_required) ok = 0;
        end
        check("blocked50", ok, 1);
        clear_inputs();
      end
    end

    start_enc(); finish_enc(0);
    start_enc(); finish_enc(0);

    ok = 1;
    host_in_valid = 1; core_in_ready = 1;
    repeat (5) begin
      @(negedge clk); #1;
      if (host_in_ready || core_in_valid) ok = 0;
    end
    check("blocked_reseed", ok, 1);
    clear_inputs();
    do_seed(0);

    start_enc(); finish_enc(0);
    @(negedge clk);
    host_in_valid = 1; host_seed_valid = 1; core_in_ready = 1; core_seed_ready = 1;
    #1;
    check("prio_in_gate", {host_in_ready, core_in_valid}, 0);
    check("prio_seed_pass", core_seed_valid, 1);
    @(negedge clk);
    host_seed_valid = 0; core_seed_ready = 0;
    #1;
    check("prio_in_next", core_in_valid, 1);
    check("prio_cnt", enc_cnt, 0);
    m_cnt = '0;
    clear_inputs();
    start_enc(); finish_enc(0);

    do_seed(0);
    start_enc(); finish_enc(1);

    start_enc();
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_seed_req", seed_required, 1);
    check("arst_cnt", enc_cnt, 0);
    #1 rst = 0;
    sb.delete();
    m_cnt = '0;
    @(negedge clk);
    host_in_valid = 1; core_in_ready = 1;
    #1 check("arst_in_block", host_in_ready, 0);
    clear_inputs();
    do_seed(1);
    start_enc(); finish_enc(0);

    @(negedge clk); zhsv = 1; zcsr = 1;
    @(negedge clk); zhsv = 0; zcsr = 0;
    zm = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); zhiv = 1; zcir = 1;
      @(negedge clk); zhiv = 0; zcir = 0; zcov = 1; zcor = 1;
      @(negedge clk); zcov = 0; zcor = 0;
      #1;
      if (zm != 2'd3) zm = zm + 2'd1;
      check($sformatf("sat_cnt%0d", i), zcnt, zm);
      check($sformatf("sat_noreseed%0d", i), zsreq, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
